// File: rtl/counter_step_ctrl.sv
// Button sequencer: debounced up/down/clear levels -> registered inc/dec/clr/sat strobes with hold-to-repeat.
// Latency: one cycle from the edge where a step is decided to its strobe; steps past MAX_VAL or 0 become sat.
module counter_step_ctrl #(
  parameter int WIDTH         = 8,
  parameter int MAX_VAL       = 255,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             up_state,
  input  logic             down_state,
  input  logic             clr_state,
  input  logic [WIDTH-1:0] count_in,
  output logic             inc,
  output logic             dec,
  output logic             clr,
  output logic             sat,
  output logic             active
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            dir_up_q, dir_up_d;
  logic            prev_up_q, prev_down_q, prev_clr_q;
  logic            inc_q, dec_q, clr_q, sat_q, active_q;
  logic            inc_d, dec_d, clr_d, sat_d;

  logic            rise_up, rise_down, rise_clr;
  logic            abort;
  logic            step_req, step_up;
  logic            at_max, at_zero;
  logic [TW-1:0]   timer_inc;

  assign rise_up   = up_state & ~prev_up_q;
  assign rise_down = down_state & ~prev_down_q;
  assign rise_clr  = clr_state & ~prev_clr_q;

  assign at_max  = (count_in == WIDTH'(MAX_VAL));
  assign at_zero = (count_in == '0);

  // The opposite button can never already be held on entry to DELAY, so its level is a fresh press.
  assign abort = dir_up_q ? (~up_state | down_state) : (~down_state | up_state);

  // Timer saturates rather than wrapping.
  assign timer_inc = (timer_q == TW'(TMAX)) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dir_up_d = dir_up_q;
    step_req = 1'b0;
    step_up  = dir_up_q;
    clr_d    = 1'b0;

    if (rise_clr) begin
      clr_d   = 1'b1;
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (rise_up && !down_state) begin
            step_req = 1'b1;
            step_up  = 1'b1;
            dir_up_d = 1'b1;
            state_d  = DELAY;
            timer_d  = TW'(1);
          end else if (rise_down && !up_state) begin
            step_req = 1'b1;
            step_up  = 1'b0;
            dir_up_d = 1'b0;
            state_d  = DELAY;
            timer_d  = TW'(1);
          end
        end
        DELAY: begin
          if (abort) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == TW'(HOLD_CYCLES)) begin
            step_req = 1'b1;
            state_d  = REPEAT;
            timer_d  = TW'(1);
          end else begin
            timer_d = timer_inc;
          end
        end
        REPEAT: begin
          if (abort) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == TW'(REPEAT_CYCLES)) begin
            step_req = 1'b1;
            timer_d  = TW'(1);
          end else begin
            timer_d = timer_inc;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    inc_d = step_req &  step_up & ~at_max;
    dec_d = step_req & ~step_up & ~at_zero;
    sat_d = step_req & (step_up ? at_max : at_zero);
  end

  always_ff @(posedge clk_in) begin
    // Edge history tracks inputs through reset so a button held across reset yields no edge.
    prev_up_q   <= up_state;
    prev_down_q <= down_state;
    prev_clr_q  <= clr_state;
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      dir_up_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      clr_q    <= 1'b0;
      sat_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      dir_up_q <= dir_up_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      clr_q    <= clr_d;
      sat_q    <= sat_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign inc    = inc_q;
  assign dec    = dec_q;
  assign clr    = clr_q;
  assign sat    = sat_q;
  assign active = active_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl: press-timeline model checked every cycle plus literal scenario expectations.
module tb_counter_step_ctrl;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_s, down_s, clr_s;
  logic [7:0] cnt;
  logic       cnt_ld;
  logic [7:0] cnt_ld_val;
  logic       inc, dec, clr, sat, active;

  int compared = 0;
  int mismatched = 0;
  int n_inc = 0, n_dec = 0, n_clr = 0, n_sat = 0, n_act = 0;

  always #5 clk = ~clk;

  counter_step_ctrl #(
    .WIDTH(8), .MAX_VAL(MAXV), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk_in(clk), .rst(rst), .up_state(up_s), .down_state(down_s), .clr_state(clr_s),
    .count_in(cnt), .inc(inc), .dec(dec), .clr(clr), .sat(sat), .active(active)
  );

  // Counter driven by the DUT strobes, as the real 8-bit counter would be.
  always @(posedge clk) begin
    if (cnt_ld) cnt <= cnt_ld_val;
    else if (clr) cnt <= 8'd0;
    else if (inc) cnt <= cnt + 8'd1;
    else if (dec) cnt <= cnt - 8'd1;
  end

  // Model: a press is a start edge index t0 and a direction; steps are due at age 0, HOLD, HOLD+k*REP.
  int         e = 0;
  int         m_t0 = 0;
  int         age;
  logic       m_arm = 1'b0, m_dir = 1'b0;
  logic       pu = 1'b0, pd = 1'b0, pc = 1'b0;
  logic [4:0] exp_v = 5'b0;   // {inc, dec, clr, sat, active}

  function automatic logic [4:0] step_out(input logic up, input logic [7:0] c);
    if (up) return (c == 8'(MAXV)) ? 5'b00010 : 5'b10000;
    else    return (c == 8'd0)     ? 5'b00010 : 5'b01000;
  endfunction

  always @(posedge clk) begin
    e = e + 1;
    exp_v = 5'b0;
    if (rst) begin
      m_arm = 1'b0;
    end else if (clr_s && !pc) begin
      exp_v[2] = 1'b1;
      m_arm = 1'b0;
    end else if (m_arm) begin
      if (m_dir ? (!up_s || down_s) : (!down_s || up_s)) begin
        m_arm = 1'b0;
      end else begin
        age = e - m_t0;
        if (age == HOLD || (age > HOLD && ((age - HOLD) % REP) == 0))
          exp_v = step_out(m_dir, cnt);
      end
    end else if (up_s && !pu && !down_s) begin
      m_arm = 1'b1; m_dir = 1'b1; m_t0 = e;
      exp_v = step_out(1'b1, cnt);
    end else if (down_s && !pd && !up_s) begin
      m_arm = 1'b1; m_dir = 1'b0; m_t0 = e;
      exp_v = step_out(1'b0, cnt);
    end
    exp_v[0] = m_arm;
    pu = up_s; pd = down_s; pc = clr_s;
  end

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle: compare DUT against the model after the edge, tally pulses, return at the negedge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("model_cycle", int'({inc, dec, clr, sat, active}), int'(exp_v));
      n_inc += int'(inc); n_dec += int'(dec); n_clr += int'(clr);
      n_sat += int'(sat); n_act += int'(active);
      @(negedge clk);
    end
  endtask

  task automatic set_count(input logic [7:0] v);
    cnt_ld = 1'b1; cnt_ld_val = v;
    tick();
    cnt_ld = 1'b0;
  endtask

  int b_inc, b_dec, b_clr, b_sat, b_act;
  task automatic snap();
    b_inc = n_inc; b_dec = n_dec; b_clr = n_clr; b_sat = n_sat; b_act = n_act;
  endtask

  initial begin
    rst = 1'b1; up_s = 1'b0; down_s = 1'b0; clr_s = 1'b0;
    cnt_ld = 1'b1; cnt_ld_val = 8'd0;
    tick(2);
    chk("reset_outs", int'({inc, dec, clr, sat, active}), 0);
    rst = 1'b0; cnt_ld = 1'b0;
    tick(2);

    // Tap
    set_count(8'd10); snap();
    up_s = 1'b1; tick();
    chk("tap_inc_latency", int'(inc), 1);
    tick(); up_s = 1'b0; tick(4);
    chk("tap_inc_count", n_inc - b_inc, 1);
    chk("tap_active_cycles", n_act - b_act, 2);
    chk("tap_count", int'(cnt), 11);

    // Hold and repeat
    set_count(8'd20); snap();
    up_s = 1'b1; tick(12); up_s = 1'b0; tick();
    chk("hold_active_drop", int'(active), 0);
    tick(3);
    chk("hold_inc_count", n_inc - b_inc, 5);
    chk("hold_count", int'(cnt), 25);
    chk("hold_no_sat", n_sat - b_sat, 0);

    // Down repeat
    set_count(8'd5); snap();
    down_s = 1'b1; tick(6); down_s = 1'b0; tick(3);
    chk("down_dec_count", n_dec - b_dec, 2);
    chk("down_count", int'(cnt), 3);

    // Saturation high and low
    set_count(8'd254); snap();
    up_s = 1'b1; tick(8); up_s = 1'b0; tick(3);
    chk("sat_hi_inc", n_inc - b_inc, 1);
    chk("sat_hi_sat", n_sat - b_sat, 2);
    chk("sat_hi_count", int'(cnt), 255);
    set_count(8'd0); snap();
    down_s = 1'b1; tick(3); down_s = 1'b0; tick(2);
    chk("sat_lo_sat", n_sat - b_sat, 1);
    chk("sat_lo_dec", n_dec - b_dec, 0);

    // Conflict
    set_count(8'd30);
    up_s = 1'b1; tick(7); snap();
    down_s = 1'b1; tick();
    chk("conflict_active", int'(active), 0);
    tick(2); down_s = 1'b0; tick(6);
    chk("conflict_no_steps", (n_inc - b_inc) + (n_dec - b_dec) + (n_sat - b_sat), 0);
    up_s = 1'b0; tick(); up_s = 1'b1; tick();
    chk("conflict_repress_inc", int'(inc), 1);
    up_s = 1'b0; tick(3);
    chk("conflict_count", int'(cnt), 34);

    // Clear beats up
    set_count(8'd77); snap();
    clr_s = 1'b1; up_s = 1'b1; tick();
    chk("clear_pulse", int'(clr), 1);
    chk("clear_no_inc", int'(inc), 0);
    tick(); clr_s = 1'b0; up_s = 1'b0; tick(3);
    chk("clear_count", int'(cnt), 0);
    chk("clear_pulses", (n_clr - b_clr) * 10 + (n_inc - b_inc), 10);

    // Reset mid-repeat with up held
    set_count(8'd40);
    up_s = 1'b1; tick(7);
    rst = 1'b1; tick();
    chk("midrst_outs", int'({inc, dec, clr, sat, active}), 0);
    rst = 1'b0; snap(); tick(6);
    chk("midrst_no_inc", n_inc - b_inc, 0);
    up_s = 1'b0; tick(); up_s = 1'b1; tick();
    chk("midrst_repress_inc", int'(inc), 1);
    up_s = 1'b0; tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
